mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (IF port) and the load/store stage (LS port) of the pipelined CPU.
- Runs a small FSM that issues one access at a time, waits a fixed memory latency, and returns data with a one-cycle ack pulse.
- LS has priority, with starvation protection for IF.
- A branch flush from the execute stage cancels an in-flight fetch.

Parameters:
- MEM_LAT, 2, cycles from the m_en cycle to the m_rdata-valid cycle; legal range ≥1.
- STARVE_MAX, 4, consecutive LS grants made while if_req is pending before IF is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  branch taken; cancels the IF transaction.
- if_req  in  1  fetch request; level; held with if_addr until if_ack.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched word; registered.
- ls_req  in  1  load/store request; level; held with ls_we, ls_addr and ls_wdata until ls_ack.
- ls_we  in  1  1 = store.
- ls_addr  in  32  data address.
- ls_wdata  in  32  store data.
- ls_ack  out  1  one-cycle completion pulse.
- ls_rdata  out  32  load data; registered; unchanged by stores.
- m_en  out  1  memory access strobe; exactly one cycle per access.
- m_we  out  1  memory write enable; qualified by m_en.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid MEM_LAT cycles after the m_en cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; kill=0; starve_cnt=0; lat_cnt=0. Any in-flight memory result is discarded.
- All outputs are registered.
- States: IDLE, BUSY, DONE.
- IDLE → BUSY at an edge where a request is selected:
  - Selection rule: if only one request is present, grant it.
  - If both are present: grant LS, unless starve_cnt == STARVE_MAX, in which case grant IF.
  - If flush=1 at the same edge, if_req is treated as 0 for selection.
  - On entry to BUSY: register grant; drive m_en=1 for exactly one cycle with m_we/m_addr/m_wdata from the granted port (m_we=0 for IF); load lat_cnt=MEM_LAT.
- BUSY: m_en=0 after the first cycle; lat_cnt decrements each cycle. In the cycle m_rdata is valid (m_en cycle + MEM_LAT):
  - at its closing edge, capture m_rdata into if_rdata or ls_rdata (load only);
  - go to DONE.
- DONE: the granted ack is 1 for this single cycle; next state is IDLE unconditionally. No arbitration occurs in DONE, so a requester dropping req at the end of its ack cycle is never re-granted.
- Timing (request first seen in cycle 0, idle arbiter):
  - m_en in cycle 1;
  - ack in cycle MEM_LAT+2;
  - IDLE in cycle MEM_LAT+3.
  - Throughput is one access per MEM_LAT+3 cycles.
- Starvation counter:
  - increments (saturating at STARVE_MAX) on each LS grant made while if_req=1;
  - clears on an IF grant, or in IDLE when if_req=0.
- Flush:
  - at any edge in BUSY with grant=IF, set kill.
  - When a killed transaction completes: if_ack stays 0, if_rdata keeps its old value, and DONE→IDLE proceeds normally; kill clears on leaving DONE.
  - flush during the DONE cycle does not retract if_ack.
  - flush has no effect on LS transactions.
- The memory access itself is never aborted; timing is identical whether or not the transaction is killed.
- Stores complete with the same latency as loads (ack in cycle MEM_LAT+2).
- Changing a request's address or data while it is granted and before its ack is illegal; the arbiter uses the values sampled at the grant edge.

Decomposition:
- Shared header (alongside the existing CPU parameter include):
  - ARB_STATE_WIDTH and state encodings IDLE=0, BUSY=1, DONE=2;
  - ARB_GRANT_IF / ARB_GRANT_LS encodings;
  - defaults for MEM_LAT and STARVE_MAX.
- One natural sub-module: mem_port_arbiter_pick. It is combinational and computes the grant from if_req, ls_req, flush and starve_cnt.
- The FSM, counters and datapath registers stay in the top module.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- IF read alone: if_req=1, if_addr=0x40 in cycle 0; m_rdata=0x20020005 in cycle 3 → m_en=1 and m_addr=0x40 in cycle 1 only; if_ack=1 and if_rdata=0x20020005 in cycle 4; busy=0 in cycle 5.
- Contention: if_req and ls_req (load, 0x100) both raised in cycle 0; LS drops req after its ack → m_addr=0x100 in cycle 1; ls_ack in cycle 4; IF m_en in cycle 6; if_ack in cycle 9.
- Starvation: ls_req held continuously with back-to-back new requests, if_req held → 4 LS grants, then the 5th grant goes to IF; starve_cnt=0 after the IF grant.
- Store: ls_we=1, ls_addr=0x200, ls_wdata=0xDEADBEEF in cycle 0 → m_en=m_we=1 and m_wdata=0xDEADBEEF in cycle 1; ls_ack in cycle 4; ls_rdata unchanged.
- Flush:
  - IF granted, flush=1 in cycle 2 → no if_ack ever for that fetch; busy falls in cycle 5; a new if_req is then served normally.
  - flush=1 at the grant edge with only if_req → no m_en.
- Reset mid-operation: rst asserted in cycle 2 of an LS load → all outputs 0 immediately (async); after release, no ls_ack appears unless ls_req is re-raised; the next access starts cleanly.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/LS unified-memory port arbiter: FSM state
// encoding, grant encoding, parameter defaults and a counter-width helper.
package mem_port_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_GRANT_IF = 1'b0,
        ARB_GRANT_LS = 1'b1
    } arb_grant_e;

    localparam int ARB_DEFAULT_MEM_LAT    = 2;
    localparam int ARB_DEFAULT_STARVE_MAX = 4;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int arb_cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection for the memory port arbiter. Purely combinational: LS wins
// contention unless IF has been passed over STARVE_MAX times in a row, and a
// flush suppresses the fetch request for the edge it is seen on.
module mem_port_arbiter_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = ARB_DEFAULT_STARVE_MAX,
    parameter int STARVE_W   = arb_cnt_width(STARVE_MAX)
) (
    input  logic                if_req,
    input  logic                ls_req,
    input  logic                flush,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_valid,
    output arb_grant_e          grant
);

    logic if_eff;
    logic starved;

    // Pick the winner among the effective requests.
    always_comb begin
        if_eff      = if_req && !flush;
        starved     = (starve_cnt == STARVE_W'(STARVE_MAX));
        grant_valid = if_eff || ls_req;
        grant       = ARB_GRANT_IF;
        if (ls_req && (!if_eff || !starved)) begin
            grant = ARB_GRANT_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (LS). One access at a time: grant, one-cycle m_en, wait MEM_LAT,
// capture read data and pulse the winner's ack. A flush during a fetch marks
// it killed so its result is silently dropped.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = ARB_DEFAULT_MEM_LAT,
    parameter int STARVE_MAX = ARB_DEFAULT_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int LAT_W    = arb_cnt_width(MEM_LAT);
    localparam int STARVE_W = arb_cnt_width(STARVE_MAX);

    arb_state_e          state;
    arb_state_e          state_next;
    arb_grant_e          grant_q;
    arb_grant_e          pick_grant;
    logic                pick_valid;
    logic                start;
    logic                finish;
    logic                if_deliver;
    logic                ls_deliver;
    logic                grant_we;
    logic                kill;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    mem_port_arbiter_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .flush       (flush),
        .starve_cnt  (starve_cnt),
        .grant_valid (pick_valid),
        .grant       (pick_grant)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the grant/finish strobes that drive the datapath.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_BUSY;
                    start      = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (lat_cnt == '0) begin
                    state_next = ARB_DONE;
                    finish     = 1'b1;
                end
            end
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
        if_deliver = finish && (grant_q == ARB_GRANT_IF) && !kill && !flush;
        ls_deliver = finish && (grant_q == ARB_GRANT_LS);
    end

    // Grant bookkeeping, latency countdown, fetch kill flag and IF starvation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= ARB_GRANT_IF;
            grant_we   <= 1'b0;
            lat_cnt    <= '0;
            kill       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (start) begin
                grant_q  <= pick_grant;
                grant_we <= (pick_grant == ARB_GRANT_LS) && ls_we;
                lat_cnt  <= LAT_W'(MEM_LAT);
            end else if ((state == ARB_BUSY) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (state == ARB_DONE) begin
                kill <= 1'b0;
            end else if ((state == ARB_BUSY) && (grant_q == ARB_GRANT_IF) && flush) begin
                kill <= 1'b1;
            end

            if (start && (pick_grant == ARB_GRANT_IF)) begin
                starve_cnt <= '0;
            end else if (start && if_req) begin
                if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end else if ((state == ARB_IDLE) && !if_req) begin
                starve_cnt <= '0;
            end
        end
    end

    // Registered memory-side strobes and requester-side acks/read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            if_rdata <= '0;
            ls_ack   <= 1'b0;
            ls_rdata <= '0;
            busy     <= 1'b0;
        end else begin
            m_en <= start;
            m_we <= start && (pick_grant == ARB_GRANT_LS) && ls_we;
            if (start) begin
                if (pick_grant == ARB_GRANT_LS) begin
                    m_addr  <= ls_addr;
                    m_wdata <= ls_wdata;
                end else begin
                    m_addr  <= if_addr;
                    m_wdata <= '0;
                end
            end
            if_ack <= if_deliver;
            ls_ack <= ls_deliver;
            if (if_deliver) begin
                if_rdata <= m_rdata;
            end
            if (ls_deliver && !grant_we) begin
                ls_rdata <= m_rdata;
            end
            busy <= (state_next != ARB_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference model
// predicts every m_en, ack and busy cycle from the arbitration rules; a
// behavioural memory answers m_en after MEM_LAT cycles; a monitor on the
// falling edge pops and compares expectations.
module tb_mem_port_arbiter;

    localparam int MEM_LAT       = 2;
    localparam int STARVE_MAX    = 4;
    localparam int RANDOM_CYCLES = 3000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } men_exp_t;
    typedef struct { int cyc; logic ack; logic [31:0] data; } ack_exp_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    men_exp_t    men_q[$];
    ack_exp_t    if_q[$];
    ack_exp_t    ls_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    bit          mon_on = 1'b0;
    bit          rnd = 1'b0;

    int          model_idle_at;
    int          last_grant;
    int          starve;
    bit          pend_active;
    bit          pend_killed;
    int          pend_g;
    logic [31:0] pend_data;
    logic [31:0] model_if_rdata;
    logic [31:0] model_ls_rdata;

    bit          if_ack_seen;
    bit          ls_ack_seen;
    bit          flush_seen;
    bit          flush_next;
    int          ls_refill;
    bit          want_if;
    logic [31:0] want_if_addr;
    bit          want_ls;
    logic        want_ls_we;
    logic [31:0] want_ls_addr;
    logic [31:0] want_ls_wdata;

    int          mon_t;
    bit          mon_hit;
    men_exp_t    mon_me;
    ack_exp_t    mon_ae;

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value seen during cycle t is t.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : defaultWord(a);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : defaultWord(a);
    endfunction

    function automatic logic [31:0] randAddr();
        return 32'($urandom_range(63)) << 2;
    endfunction

    // Behavioural memory: accept the access on m_en, answer MEM_LAT cycles later.
    always @(negedge clk) begin
        if (!rst && m_en) begin
            if (m_we) mem[m_addr] = m_wdata;
            else rsp_q.push_back('{cyc + MEM_LAT, memRead(m_addr)});
        end
    end

    // Read data is only meaningful in its due cycle; garbage otherwise.
    always @(posedge clk) begin
        #1;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) m_rdata = rsp_q.pop_front().data;
        else m_rdata = $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        men_q.delete();
        if_q.delete();
        ls_q.delete();
        rsp_q.delete();
        model_idle_at  = 0;
        last_grant     = -100;
        starve         = 0;
        pend_active    = 1'b0;
        pend_killed    = 1'b0;
        model_if_rdata = '0;
        model_ls_rdata = '0;
        if_ack_seen    = 1'b0;
        ls_ack_seen    = 1'b0;
        flush_seen     = 1'b0;
        flush_next     = 1'b0;
        ls_refill      = 0;
        want_if        = 1'b0;
        want_ls        = 1'b0;
    endtask

    // Reference model for the cycle now being driven: decides what the edge at
    // its end does and schedules the resulting observable events.
    task automatic modelStep();
        int t = cyc;
        bit eff_if;
        bit pick_ls;
        logic [31:0] d;
        if (pend_active) begin
            if (flush && t >= pend_g + 1 && t <= pend_g + MEM_LAT + 1) pend_killed = 1'b1;
            if (t == pend_g + MEM_LAT + 1) begin
                if (pend_killed) begin
                    if_q.push_back('{t + 1, 1'b0, model_if_rdata});
                end else begin
                    model_if_rdata = pend_data;
                    if_q.push_back('{t + 1, 1'b1, pend_data});
                end
                pend_active = 1'b0;
            end
        end
        if (t >= model_idle_at) begin
            eff_if = if_req && !flush;
            if (eff_if || ls_req) begin
                pick_ls       = ls_req && (!eff_if || starve < STARVE_MAX);
                last_grant    = t;
                model_idle_at = t + MEM_LAT + 3;
                if (pick_ls) begin
                    starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                    men_q.push_back('{t + 1, ls_addr, ls_we, ls_wdata});
                    if (ls_we) begin
                        model_mem[ls_addr] = ls_wdata;
                    end else begin
                        d = modelRead(ls_addr);
                        model_ls_rdata = d;
                    end
                    ls_q.push_back('{t + MEM_LAT + 2, 1'b1, model_ls_rdata});
                end else begin
                    starve = 0;
                    men_q.push_back('{t + 1, if_addr, 1'b0, 32'h0});
                    pend_active = 1'b1;
                    pend_killed = 1'b0;
                    pend_g      = t;
                    pend_data   = modelRead(if_addr);
                end
            end else if (!if_req) begin
                starve = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lsr,
                                 input logic lwe, input logic [31:0] la, input logic [31:0] lw,
                                 input logic fl);
        if_req   = ifr;
        if_addr  = ifa;
        ls_req   = lsr;
        ls_we    = lwe;
        ls_addr  = la;
        ls_wdata = lw;
        flush    = fl;
        modelStep();
    endtask

    // One cycle of requester behaviour: hold until ack, drop fetch after flush.
    task automatic tick();
        logic nifr, nlsr, nlwe, nfl;
        logic [31:0] nifa, nla, nlw;
        @(posedge clk);
        #1;
        nifr = if_req; nifa = if_addr;
        nlsr = ls_req; nlwe = ls_we; nla = ls_addr; nlw = ls_wdata;
        if (if_ack_seen || flush_seen) nifr = 1'b0;
        if (ls_ack_seen) begin
            nlsr = 1'b0;
            if (ls_refill > 0) begin
                ls_refill--;
                nlsr = 1'b1; nlwe = 1'b0; nla = randAddr(); nlw = $urandom;
            end
        end
        if (want_if) begin nifr = 1'b1; nifa = want_if_addr; want_if = 1'b0; end
        if (want_ls) begin
            nlsr = 1'b1; nlwe = want_ls_we; nla = want_ls_addr; nlw = want_ls_wdata;
            want_ls = 1'b0;
        end
        nfl = flush_next;
        flush_next = 1'b0;
        if (rnd) begin
            if (!nifr && $urandom_range(2) == 0) begin nifr = 1'b1; nifa = randAddr(); end
            if (!nlsr && $urandom_range(2) == 0) begin
                nlsr = 1'b1; nlwe = 1'($urandom_range(1)); nla = randAddr(); nlw = $urandom;
            end
            if ($urandom_range(9) == 0) nfl = 1'b1;
        end
        applyStimulus(nifr, nifa, nlsr, nlwe, nla, nlw, nfl);
        if_ack_seen = if_ack;
        ls_ack_seen = ls_ack;
        flush_seen  = nfl;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reqLs(input logic we, input logic [31:0] a, input logic [31:0] d);
        want_ls = 1'b1; want_ls_we = we; want_ls_addr = a; want_ls_wdata = d;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_if_ack"}, 32'(if_ack), 32'h0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 32'h0);
        checkOutput({tag, "_ls_ack"}, 32'(ls_ack), 32'h0);
        checkOutput({tag, "_ls_rdata"}, ls_rdata, 32'h0);
        checkOutput({tag, "_m_en"}, 32'(m_en), 32'h0);
        checkOutput({tag, "_m_we"}, 32'(m_we), 32'h0);
        checkOutput({tag, "_m_addr"}, m_addr, 32'h0);
        checkOutput({tag, "_m_wdata"}, m_wdata, 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Scoreboard monitor: every cycle, compare busy and each output event.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_t = cyc;
            checkOutput("busy", 32'(busy),
                        32'((mon_t > last_grant) && (mon_t < last_grant + MEM_LAT + 3)));
            mon_hit = (men_q.size() > 0) && (men_q[0].cyc == mon_t);
            checkOutput("m_en", 32'(m_en), 32'(mon_hit));
            if (mon_hit) begin
                mon_me = men_q.pop_front();
                if (m_en) begin
                    checkOutput("m_addr", m_addr, mon_me.addr);
                    checkOutput("m_we", 32'(m_we), 32'(mon_me.we));
                    if (mon_me.we) checkOutput("m_wdata", m_wdata, mon_me.wdata);
                end
            end
            mon_hit = (if_q.size() > 0) && (if_q[0].cyc == mon_t);
            if (mon_hit) begin
                mon_ae = if_q.pop_front();
                checkOutput("if_ack", 32'(if_ack), 32'(mon_ae.ack));
                checkOutput("if_rdata", if_rdata, mon_ae.data);
            end else begin
                checkOutput("if_ack", 32'(if_ack), 32'h0);
            end
            mon_hit = (ls_q.size() > 0) && (ls_q[0].cyc == mon_t);
            if (mon_hit) begin
                mon_ae = ls_q.pop_front();
                checkOutput("ls_ack", 32'(ls_ack), 32'h1);
                checkOutput("ls_rdata", ls_rdata, mon_ae.data);
            end else begin
                checkOutput("ls_ack", 32'(ls_ack), 32'h0);
            end
        end
    end

    // Main sequence: directed scenarios, randomized traffic, drain and summary.
    initial begin
        rst = 1'b1;
        m_rdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        modelReset();
        mon_on = 1'b1;

        $display("[TB] IF read alone");
        mem[32'h40] = 32'h2002_0005;
        model_mem[32'h40] = 32'h2002_0005;
        want_if = 1'b1; want_if_addr = 32'h40;
        runCycles(8);

        $display("[TB] contention");
        want_if = 1'b1; want_if_addr = 32'h80;
        reqLs(1'b0, 32'h100, 32'h0);
        runCycles(14);

        $display("[TB] store keeps ls_rdata");
        reqLs(1'b0, 32'h104, 32'h0);
        runCycles(6);
        reqLs(1'b1, 32'h200, 32'hDEAD_BEEF);
        runCycles(6);
        reqLs(1'b0, 32'h200, 32'h0);
        runCycles(6);

        $display("[TB] starvation");
        want_if = 1'b1; want_if_addr = 32'hC0;
        reqLs(1'b0, 32'h10, 32'h0);
        ls_refill = 4;
        runCycles(40);

        $display("[TB] flush in flight");
        want_if = 1'b1; want_if_addr = 32'h44;
        runCycles(2);
        flush_next = 1'b1;
        runCycles(6);
        want_if = 1'b1; want_if_addr = 32'h48;
        runCycles(8);

        $display("[TB] flush at grant edge");
        want_if = 1'b1; want_if_addr = 32'h4C;
        flush_next = 1'b1;
        runCycles(6);

        $display("[TB] reset mid-operation");
        reqLs(1'b0, 32'h300, 32'h0);
        runCycles(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_on = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
        modelReset();
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        mon_on = 1'b1;
        runCycles(6);
        reqLs(1'b0, 32'h304, 32'h0);
        runCycles(6);

        $display("[TB] randomized traffic");
        rnd = 1'b1;
        runCycles(RANDOM_CYCLES);
        rnd = 1'b0;
        runCycles(40);

        checkOutput("men_q_drained", 32'(men_q.size()), 32'h0);
        checkOutput("if_q_drained", 32'(if_q.size()), 32'h0);
        checkOutput("ls_q_drained", 32'(ls_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
